rr_stream_arbiter: RTL and testbench

Round-robin N:1 arbiter for valid/ready streams. It merges N upstream master ports onto one downstream slave port through a single registered output stage, one beat per cycle. It sits in front of shared consumers such as a single-ported sink or a ready-registered pipeline stage. It tags each output beat with the index of the winning requester.

---
 rtl/rr_stream_arbiter.sv | 162 ++++++++++++++++
 tb/tb_rr_stream_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter
//   Round-robin N:1 arbiter merging N valid/ready upstream streams onto one
//   registered downstream stream, one beat per cycle. Each output beat is
//   tagged with the index of the requester that supplied it.
//
//   Optional feature macro: RR_ARB_PKT_LOCK_EN
//     Defined   : a requester that wins with m_last = 0 keeps exclusive grant
//                 until its m_last = 1 beat transfers.
//     Undefined : every beat is arbitrated independently. m_last is only
//                 forwarded to s_last.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-low reset
//   m_valid  [N]        per-requester valid
//   m_ready  [N]        per-requester ready (one-hot or zero, combinational)
//   m_data   [N*WIDTH]  requester i at bits [i*WIDTH +: WIDTH]
//   m_last   [N]        per-requester end-of-packet marker
//   s_valid             registered output valid
//   s_ready             downstream ready
//   s_data   [WIDTH]    registered output data
//   s_id     [IDW]      index of the requester that supplied s_data
//   s_last              registered copy of the winner's m_last

module rr_stream_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       m_valid,
  output logic [N-1:0]       m_ready,
  input  logic [N*WIDTH-1:0] m_data,
  input  logic [N-1:0]       m_last,
  output logic               s_valid,
  input  logic               s_ready,
  output logic [WIDTH-1:0]   s_data,
  output logic [IDW-1:0]     s_id,
  output logic               s_last
);

  logic [IDW-1:0]   ptr_q;     // last granted requester
  logic [N-1:0]     elig;      // eligible requesters this cycle
  logic             ld;        // output register may load
  logic             found;     // some requester is eligible
  logic [IDW-1:0]   gnt;       // winning requester index
  logic             xfer;      // upstream handshake happens this cycle
  logic [WIDTH-1:0] win_data;
  logic             win_last;

  // The output register can take a beat when empty or being drained.
  assign ld = s_ready | ~s_valid;

`ifdef RR_ARB_PKT_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

  lock_state_e    state_q, state_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;

  // While locked only the owner may be granted; others stay masked even if
  // the owner momentarily drops m_valid.
  always_comb begin
    elig = m_valid;
    if (state_q == LOCKED) begin
      elig = '0;
      for (int i = 0; i < N; i++) begin
        if (lock_id_q == IDW'(i)) elig[i] = m_valid[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      UNLOCKED: if (xfer && !win_last) begin
        state_d   = LOCKED;
        lock_id_d = gnt;
      end
      LOCKED:   if (xfer && win_last) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= UNLOCKED;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end
`else
  assign elig = m_valid;
`endif

  // Round-robin search: rotate the eligible set so that bit 0 is ptr+1, take
  // the lowest set bit, then map the offset back to an absolute index.
  // NOTE: every signal driven here gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             idx;
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    dbl   = {elig, elig};
    rot   = N'(dbl >> (int'(ptr_q) + 1));
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = int'(ptr_q) + 1 + i;
        if (idx >= N) idx = idx - N;
        gnt   = IDW'(idx);
      end
    end
  end

  // Handshake is gated by rst so m_ready stays low throughout reset.
  assign xfer = rst & ld & found;

  always_comb begin
    m_ready  = '0;
    win_data = '0;
    win_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt == IDW'(i)) begin
        m_ready[i] = xfer;
        win_data   = m_data[i*WIDTH +: WIDTH];
        win_last   = m_last[i];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  // NOTE: the data/id/last registers are reset as well because their reset
  // values are visible on the ports, not just a don't-care payload.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_valid <= 1'b0;
      s_data  <= '0;
      s_id    <= '0;
      s_last  <= 1'b0;
      ptr_q   <= IDW'(N - 1);
    end else if (ld) begin
      if (xfer) begin
        s_valid <= 1'b1;
        s_data  <= win_data;
        s_id    <= gnt;
        s_last  <= win_last;
        ptr_q   <= gnt;
      end else begin
        s_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
module tb_rr_stream_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [N-1:0]       m_valid = '0;
  logic [N-1:0]       m_ready;
  logic [N*WIDTH-1:0] m_data = '0;
  logic [N-1:0]       m_last = '0;
  logic               s_valid;
  logic               s_ready = 1'b0;
  logic [WIDTH-1:0]   s_data;
  logic [IDW-1:0]     s_id;
  logic               s_last;

  always #5 clk = ~clk;

  rr_stream_arbiter #(.N(N), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk     (clk),
    .rst     (rst),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_id    (s_id),
    .s_last  (s_last)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int               id;
    logic             last;
  } beat_t;

  beat_t sb_q[$];      // beats expected downstream, in order
  int    id_log[$];    // ids of beats observed leaving the DUT

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: plain integers describing the arbiter's rules.
  int m_ptr       = N - 1;
  bit m_locked    = 1'b0;
  int m_owner     = 0;
  bit m_out_valid = 1'b0;
  bit primed      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict m_ready for the present inputs, compare, and advance the model
  // to the state it will have after the coming clock edge.
  task automatic model_step();
    logic [N-1:0]       exp_ready;
    logic [N*WIDTH-1:0] sh;
    beat_t              b;
    bit                 ld;
    int                 g;
    exp_ready = '0;
    g = -1;
    if (primed) check("s_valid", s_valid, m_out_valid);
    if (!rst) begin
      check("m_ready_in_reset", m_ready, '0);
      m_ptr = N - 1; m_locked = 1'b0; m_owner = 0; m_out_valid = 1'b0;
      sb_q.delete();
      primed = 1'b1;
      return;
    end
    primed = 1'b1;
    ld = s_ready || !m_out_valid;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (g < 0 && m_valid[i] && (!m_locked || i == m_owner)) g = i;
    end
    if (ld && g >= 0) exp_ready[g] = 1'b1;
    check("m_ready", m_ready, exp_ready);
    if (ld) begin
      if (g >= 0) begin
        sh = m_data >> (g * WIDTH);
        b.data = sh[WIDTH-1:0];
        b.id   = g;
        b.last = m_last[g];
        sb_q.push_back(b);
        m_ptr = g;
`ifdef RR_ARB_PKT_LOCK_EN
        if (!m_locked && !b.last) begin
          m_locked = 1'b1;
          m_owner  = g;
        end else if (m_locked && b.last) begin
          m_locked = 1'b0;
        end
`endif
        m_out_valid = 1'b1;
      end else begin
        m_out_valid = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs just after the falling edge, then check.
  task automatic step(input logic [N-1:0] v, input logic [N*WIDTH-1:0] d,
                      input logic [N-1:0] l, input logic rdy, input logic r);
    @(negedge clk);
    m_valid = v;
    m_data  = d;
    m_last  = l;
    s_ready = rdy;
    rst     = r;
    #1;
    model_step();
  endtask

  // Monitor: samples shortly before the rising edge; whenever a beat is held
  // it must match the head of the scoreboard, and it is retired on s_ready.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst && s_valid) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got id %0d data %0h, expected no beat", s_id, s_data);
        end else begin
          check("s_data", s_data, sb_q[0].data);
          check("s_id",   s_id,   sb_q[0].id);
          check("s_last", s_last, sb_q[0].last);
          if (s_ready) begin
            id_log.push_back(int'(s_id));
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int cnt1;
    int exp_ids[4];

    // Reset, then idle with s_ready high.
    step('0, '0, '0, 1'b1, 1'b0);
    step('0, '0, '0, 1'b1, 1'b0);
    step('0, '0, '0, 1'b1, 1'b1);
    check("idle_m_ready", m_ready, 4'b0000);

    // Single requester 0 with A5.
    step(4'b0001, 32'h0000_00A5, 4'b0001, 1'b1, 1'b1);
    check("first_grant", m_ready, 4'b0001);
    step('0, '0, '0, 1'b1, 1'b1);
    check("first_data", s_data, 8'hA5);
    check("first_id",   s_id,   0);

    // All four valid, streaming at full rate.
    for (int c = 0; c < 12; c++)
      step(4'b1111, {$urandom}, 4'b1111, 1'b1, 1'b1);

    // Downstream stall for three cycles, then release.
    for (int c = 0; c < 3; c++)
      step(4'b1111, {$urandom}, 4'b1111, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++)
      step(4'b1111, {$urandom}, 4'b1111, 1'b1, 1'b1);

    // Reset during a stall.
    step(4'b1111, {$urandom}, 4'b1111, 1'b0, 1'b1);
    step(4'b1111, {$urandom}, 4'b1111, 1'b0, 1'b0);
    step('0, '0, '0, 1'b0, 1'b1);
    check("s_id_after_reset", s_id, 0);
    step(4'b1111, {$urandom}, 4'b1111, 1'b1, 1'b1);
    check("winner_after_reset", m_ready, 4'b0001);
    step('0, '0, '0, 1'b1, 1'b1);

    // Packet from requester 1 (last = 0,0,1) competing with requester 2.
    step('0, '0, '0, 1'b1, 1'b0);
    step('0, '0, '0, 1'b1, 1'b1);
    id_log.delete();
    cnt1 = 0;
    for (int c = 0; c < 8; c++) begin
      logic [N*WIDTH-1:0] d;
      logic [N-1:0]       l;
      d = {8'h00, 8'h20 + 8'(c), 8'h10 + 8'(cnt1), 8'h00};
      l = {1'b0, 1'b1, (cnt1 % 3) == 2, 1'b0};
      step(4'b0110, d, l, 1'b1, 1'b1);
      if (m_ready[1]) cnt1++;
    end
    step('0, '0, '0, 1'b1, 1'b1);
    step('0, '0, '0, 1'b1, 1'b1);
`ifdef RR_ARB_PKT_LOCK_EN
    exp_ids = '{1, 1, 1, 2};
`else
    exp_ids = '{1, 2, 1, 2};
`endif
    check("pkt_beats_seen", id_log.size() >= 4, 1'b1);
    for (int k = 0; k < 4; k++)
      if (k < id_log.size()) check($sformatf("pkt_id_%0d", k), id_log[k], exp_ids[k]);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++)
      step(N'($urandom), {$urandom}, N'($urandom),
           ($urandom % 4) != 0, ($urandom % 80) != 0);

    // Drain and confirm every expected beat left the DUT.
    for (int c = 0; c < 4; c++)
      step('0, '0, '0, 1'b1, 1'b1);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
